cv32e40p_obi_stall_bridge: RTL and testbench

//  OBI stall-injection bridge between a cv32e40p core memory port (instr or data) and mm_ram.

---
 rtl/cv32e40p_obi_stall_bridge_if.sv | 24 ++
 rtl/cv32e40p_obi_stall_bridge.sv | 143 ++++++++++++++
 tb/tb_cv32e40p_obi_stall_bridge.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_obi_stall_bridge_if.sv
// OBI request/response bundle shared by the core side and the mm_ram side of the stall bridge.
interface cv32e40p_obi_stall_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/cv32e40p_obi_stall_bridge.sv
// OBI stall-injection bridge: holds off grants and read responses of one core memory port
// by run-time programmable cycle counts, without touching the memory model behind it.
module cv32e40p_obi_stall_bridge #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DELAY_WIDTH     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DELAY_WIDTH-1:0]      gnt_delay_i,
  input  logic [DELAY_WIDTH-1:0]      rvalid_delay_i,
  cv32e40p_obi_stall_bridge_if.slave  core,
  cv32e40p_obi_stall_bridge_if.master mem
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {StIdle, StStall, StFwd} state_e;

  state_e                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [CntW-1:0]        outst_q, outst_d;
  logic                   room;

  logic [DATA_WIDTH-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]        wptr_q, rptr_q;
  logic [CntW-1:0]        fcnt_q, fcnt_d;
  logic [DELAY_WIDTH-1:0] timer_q, timer_d;
  logic                   push, pop, head_rdy, head_load, accept;
  logic [ADDR_WIDTH-1:0]  addr_fwd;

  assign addr_fwd  = core.addr;
  assign mem.addr  = addr_fwd;
  assign mem.we    = core.we;
  assign mem.be    = core.be;
  assign mem.wdata = core.wdata;

  assign room   = outst_q < MaxCnt;
  assign accept = core.gnt & core.req;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem.req  = 1'b0;
    core.gnt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (core.req && room) begin
          if (gnt_delay_i == '0) begin
            mem.req  = 1'b1;
            core.gnt = mem.gnt;
            if (!mem.gnt) state_d = StFwd;
          end else if (gnt_delay_i == DELAY_WIDTH'(1)) begin
            state_d = StFwd;
          end else begin
            // The acceptance cycle is the first of the gnt_delay_i low cycles.
            cnt_d   = gnt_delay_i - DELAY_WIDTH'(1);
            state_d = StStall;
          end
        end
      end
      StStall: begin
        cnt_d = cnt_q - DELAY_WIDTH'(1);
        if (cnt_q == DELAY_WIDTH'(1)) state_d = StFwd;
      end
      StFwd: begin
        mem.req  = 1'b1;
        core.gnt = mem.gnt;
        if (mem.gnt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign push        = mem.rvalid;
  assign head_rdy    = (fcnt_q != '0) && (timer_q == '0);
  assign pop         = head_rdy;
  assign core.rvalid = head_rdy;
  assign core.rdata  = head_rdy ? fifo_q[rptr_q] : '0;

  // A new head starts its own hold time, whether it arrived into an empty FIFO or moved up.
  assign head_load = (push && (fcnt_q == '0)) || (pop && ((fcnt_q > CntW'(1)) || push));

  always_comb begin
    outst_d = outst_q;
    if (accept && !pop) begin
      outst_d = outst_q + 1'b1;
    end else if (!accept && pop) begin
      outst_d = outst_q - 1'b1;
    end
    fcnt_d = fcnt_q;
    if (push && !pop) begin
      fcnt_d = fcnt_q + 1'b1;
    end else if (pop && !push) begin
      fcnt_d = fcnt_q - 1'b1;
    end
    timer_d = timer_q;
    if (head_load) begin
      timer_d = rvalid_delay_i;
    end else if (timer_q != '0) begin
      timer_d = timer_q - DELAY_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      outst_q <= '0;
      fcnt_q  <= '0;
      timer_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      fcnt_q  <= fcnt_d;
      timer_q <= timer_d;
      if (push) begin
        fifo_q[wptr_q] <= mem.rdata;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
    end
  end

  req_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    core.req && !core.gnt |=> core.req);

  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (fcnt_q == MaxCnt)));

endmodule

// File: tb/tb_cv32e40p_obi_stall_bridge.sv
// Bench for the OBI stall bridge: directed scenarios plus randomized traffic against a
// cycle-timeline reference model of grant release times and response hold times.
module tb_cv32e40p_obi_stall_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MAXO = 2;
  localparam int unsigned DLW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DLW-1:0] gnt_delay = '0;
  logic [DLW-1:0] rvalid_delay = '0;

  always #5 clk = ~clk;

  cv32e40p_obi_stall_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) core_bus ();
  cv32e40p_obi_stall_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  cv32e40p_obi_stall_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .DELAY_WIDTH(DLW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .gnt_delay_i(gnt_delay),
    .rvalid_delay_i(rvalid_delay),
    .core(core_bus),
    .mem(mem_bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int t; logic [DW-1:0] d;} rsp_t;
  rsp_t sched[$];
  int last_t = 0;
  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  bit jitter = 0;
  int cyc = 0;

  // Reference model: absolute cycle at which the accepted request / queue head is released.
  bit m_acc = 0;
  int m_rel = 0;
  int m_outst = 0;
  logic [DW-1:0] m_q[$];
  int m_head_rel = 0;

  bit granted, req_out;
  int last_grant_cyc;
  logic [AW-1:0] g_addr;
  logic g_we;
  logic [DW/8-1:0] g_be;
  logic [DW-1:0] g_wdata;
  int rvo_cyc[$];
  int rvi_cyc[$];
  logic [DW-1:0] rvo_dat[$];
  logic [DW-1:0] rvi_dat[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    rvo_cyc.delete();
    rvi_cyc.delete();
    rvo_dat.delete();
    rvi_dat.delete();
  endtask

  task automatic step();
    bit exp_req, exp_gnt, exp_rv, was_empty;
    logic [DW-1:0] exp_rd;
    rsp_t r;
    int t;
    if (jitter) begin
      gnt_delay    = DLW'($urandom_range(3, 0));
      rvalid_delay = DLW'($urandom_range(4, 0));
    end
    mem_bus.gnt = ($urandom_range(99, 0) < gnt_pct);
    if (sched.size() != 0 && sched[0].t == cyc) begin
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = sched[0].d;
      void'(sched.pop_front());
    end else begin
      mem_bus.rvalid = 1'b0;
      mem_bus.rdata  = $urandom;
    end
    #1;
    if (!m_acc && core_bus.req && m_outst < int'(MAXO)) begin
      m_acc = 1;
      m_rel = cyc + int'(gnt_delay);
    end
    exp_req = m_acc && (cyc >= m_rel);
    exp_gnt = exp_req && mem_bus.gnt;
    exp_rv  = (m_q.size() != 0) && (cyc >= m_head_rel);
    exp_rd  = exp_rv ? m_q[0] : '0;
    chk("req_o", mem_bus.req, exp_req);
    chk("gnt_o", core_bus.gnt, exp_gnt);
    chk("rvalid_o", core_bus.rvalid, exp_rv);
    chk("rdata_o", core_bus.rdata, exp_rd);
    chk("addr_o", mem_bus.addr, core_bus.addr);
    chk("we_o", mem_bus.we, core_bus.we);
    chk("be_o", mem_bus.be, core_bus.be);
    chk("wdata_o", mem_bus.wdata, core_bus.wdata);
    granted = core_bus.gnt && core_bus.req;
    req_out = mem_bus.req;
    if (granted) begin
      last_grant_cyc = cyc;
      g_addr = mem_bus.addr;
      g_we = mem_bus.we;
      g_be = mem_bus.be;
      g_wdata = mem_bus.wdata;
    end
    if (core_bus.rvalid) begin
      rvo_cyc.push_back(cyc);
      rvo_dat.push_back(core_bus.rdata);
    end
    if (mem_bus.rvalid) begin
      rvi_cyc.push_back(cyc);
      rvi_dat.push_back(mem_bus.rdata);
    end
    // mm_ram stand-in: one in-order response per downstream grant.
    if (mem_bus.req && mem_bus.gnt) begin
      t = cyc + int'($urandom_range(lat_max, lat_min));
      if (t <= last_t) t = last_t + 1;
      r.t = t;
      r.d = $urandom;
      sched.push_back(r);
      last_t = t;
    end
    if (exp_gnt) m_acc = 0;
    m_outst = m_outst + int'(exp_gnt) - int'(exp_rv);
    was_empty = (m_q.size() == 0);
    if (exp_rv) void'(m_q.pop_front());
    if (mem_bus.rvalid) m_q.push_back(mem_bus.rdata);
    if (m_q.size() != 0 && (exp_rv || was_empty)) m_head_rel = cyc + 1 + int'(rvalid_delay);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW/8-1:0] b,
                       input logic [DW-1:0] d, output int first_req, output int grant_at);
    core_bus.req = 1'b1;
    core_bus.addr = a;
    core_bus.we = w;
    core_bus.be = b;
    core_bus.wdata = d;
    first_req = -1;
    grant_at = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (req_out && first_req < 0) first_req = i;
      if (granted) begin
        grant_at = i;
        break;
      end
    end
    chk("grant_seen", grant_at >= 0, 1);
    core_bus.req = 1'b0;
    core_bus.addr = $urandom;
    core_bus.wdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      done = (m_q.size() == 0) && (sched.size() == 0) && !m_acc;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    core_bus.req = 1'b0;
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b0;
    #1;
    chk("rst_req_o", mem_bus.req, 0);
    chk("rst_gnt_o", core_bus.gnt, 0);
    chk("rst_rvalid_o", core_bus.rvalid, 0);
    chk("rst_rdata_o", core_bus.rdata, 0);
    sched.delete();
    m_q.delete();
    m_acc = 0;
    m_outst = 0;
    last_t = cyc;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int fr, ga, g3;
    core_bus.req = 1'b0;
    core_bus.addr = '0;
    core_bus.we = 1'b0;
    core_bus.be = '0;
    core_bus.wdata = '0;
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata = '0;
    @(negedge clk);
    do_reset();

    // Pass-through read with no added delay.
    clear_obs();
    gnt_delay = 0; rvalid_delay = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    issue(32'h180, 1'b0, 4'hF, 32'h0, fr, ga);
    chk("d0_first_req", fr, 0);
    chk("d0_grant", ga, 0);
    drain();
    chk("d0_latency", rvo_cyc[0] - rvi_cyc[0], 1);
    chk("d0_data", rvo_dat[0], rvi_dat[0]);

    // Grant delay of 3, first with an always-ready memory, then a sluggish one.
    gnt_delay = 3;
    issue(32'h200, 1'b0, 4'hF, 32'h0, fr, ga);
    chk("gd3_first_req", fr, 3);
    chk("gd3_grant", ga, 3);
    gnt_pct = 50;
    issue(32'h204, 1'b0, 4'hF, 32'h0, fr, ga);
    chk("gd3_first_req_slow", fr, 3);
    chk("gd3_grant_late", ga >= 3, 1);
    drain();

    // Three back-to-back reads against an outstanding limit of 2.
    clear_obs();
    gnt_delay = 0; rvalid_delay = 5; gnt_pct = 100;
    issue(32'h300, 1'b0, 4'hF, 32'h0, fr, ga);
    issue(32'h304, 1'b0, 4'hF, 32'h0, fr, ga);
    issue(32'h308, 1'b0, 4'hF, 32'h0, fr, ga);
    g3 = last_grant_cyc;
    drain();
    chk("max_rsp_count", rvo_dat.size(), 3);
    chk("max_third_gnt", g3, rvo_cyc[0] + 1);
    for (int i = 0; i < rvo_dat.size() && i < rvi_dat.size(); i++) chk("max_order", rvo_dat[i], rvi_dat[i]);

    // Write with both delays at 2.
    clear_obs();
    gnt_delay = 2; rvalid_delay = 2;
    issue(32'h1000, 1'b1, 4'b0011, 32'hDEADBEEF, fr, ga);
    chk("wr_first_req", fr, 2);
    chk("wr_addr_o", g_addr, 32'h1000);
    chk("wr_we_o", g_we, 1);
    chk("wr_be_o", g_be, 4'b0011);
    chk("wr_wdata_o", g_wdata, 32'hDEADBEEF);
    drain();
    chk("wr_rsp_count", rvo_cyc.size(), 1);
    chk("wr_latency", rvo_cyc[0] - rvi_cyc[0], 3);

    // Second response lands in the same cycle the first is popped.
    clear_obs();
    gnt_delay = 0; rvalid_delay = 2; lat_min = 1; lat_max = 1;
    issue(32'h400, 1'b0, 4'hF, 32'h0, fr, ga);
    lat_min = 3; lat_max = 3;
    issue(32'h404, 1'b0, 4'hF, 32'h0, fr, ga);
    drain();
    chk("pp_same_cycle", rvi_cyc[1], rvo_cyc[0]);
    chk("pp_next_head", rvo_cyc[1] - rvo_cyc[0], 3);
    chk("pp_data1", rvo_dat[1], rvi_dat[1]);

    // Randomized traffic with delays changing every cycle.
    jitter = 1;
    for (int n = 0; n < 200; n++) begin
      gnt_pct = int'($urandom_range(100, 30));
      lat_max = int'($urandom_range(6, 1));
      lat_min = 1;
      issue($urandom, 1'($urandom_range(1, 0)), 4'($urandom), $urandom, fr, ga);
      idle(int'($urandom_range(2, 0)));
    end
    drain();
    jitter = 0;

    // Reset while stalling with one response still held.
    gnt_delay = 0; rvalid_delay = 15; gnt_pct = 100; lat_min = 1; lat_max = 1;
    issue(32'h500, 1'b0, 4'hF, 32'h0, fr, ga);
    idle(2);
    chk("rs_buffered", m_q.size(), 1);
    gnt_delay = 10;
    core_bus.req = 1'b1;
    core_bus.addr = 32'h504;
    core_bus.we = 1'b0;
    step();
    step();
    do_reset();
    clear_obs();
    idle(30);
    chk("rs_no_rsp", rvo_cyc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
